// File: rtl/rgb_pwm_pkg.sv
// Shared constants for the RGB LED PWM controller: register map, duty field layout
// and counter widths.
package rgb_pwm_pkg;

  localparam int DUTY_W  = 8;
  localparam int BLINK_W = 8;
  localparam int NUM_CH  = 3;

  localparam logic [7:0] ADDR_CTRL     = 8'h08;
  localparam logic [7:0] ADDR_STATUS   = 8'h09;
  localparam logic [7:0] ADDR_DUTY     = 8'h10;
  localparam logic [7:0] ADDR_PRESCALE = 8'h11;
  localparam logic [7:0] ADDR_BLINK    = 8'h12;

  localparam int DUTY_R_LSB = 16;
  localparam int DUTY_G_LSB = 8;
  localparam int DUTY_B_LSB = 0;

  localparam int BLINK_ON_LSB  = 8;
  localparam int BLINK_OFF_LSB = 0;

  // Channel 0/1/2 = R/G/B, matching pwm[0]/[1]/[2].
  function automatic int duty_lsb(input int ch);
    case (ch)
      0:       return DUTY_R_LSB;
      1:       return DUTY_G_LSB;
      default: return DUTY_B_LSB;
    endcase
  endfunction

endpackage

// File: rtl/rgb_pwm_ctrl_if.sv
// Core-bus register access port of the RGB PWM controller.
interface rgb_pwm_ctrl_if;

  // cs is a one-cycle request qualified by we; there is no backpressure, so every
  // cs is accepted and ready pulses for exactly one cycle on the following cycle,
  // with read_data valid only while ready=1.
  logic        cs;
  logic        we;
  logic [7:0]  address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (output cs, output we, output address, output write_data,
                  input read_data, input ready);
  modport slave  (input cs, input we, input address, input write_data,
                  output read_data, output ready);

endinterface

// File: rtl/rgb_pwm_timebase.sv
// Prescaler and 8-bit period counter shared by all PWM channels; held at zero while
// disabled so that enabling always starts a fresh period.
module rgb_pwm_timebase
  import rgb_pwm_pkg::*;
#(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick,
  output logic                  wrap,
  output logic [DUTY_W-1:0]     pcnt
);

  logic [PRESCALE_W-1:0] psc;

  // >= rather than == so that lowering prescale below the running count ticks at once.
  assign tick = enable && (psc >= prescale);
  assign wrap = tick && (pcnt == '1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      psc  <= '0;
      pcnt <= '0;
    end else if (!enable) begin
      psc  <= '0;
      pcnt <= '0;
    end else if (tick) begin
      psc  <= '0;
      pcnt <= pcnt + 1'b1;
    end else begin
      psc  <= psc + 1'b1;
    end
  end

endmodule

// File: rtl/rgb_pwm_ctrl.sv
// Memory-mapped PWM controller for the iCE40 RGB LED driver with double-buffered duty.
// Optional period blinking is built when RGB_PWM_BLINK_EN is defined.
module rgb_pwm_ctrl
  import rgb_pwm_pkg::*;
#(
  parameter int PRESCALE_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  rgb_pwm_ctrl_if.slave     bus,
  output logic              led_en,
  output logic [NUM_CH-1:0] pwm,
  output logic              period_start
);

  logic                  enable;
  logic                  enable_nxt;
  logic                  pending;
  logic [PRESCALE_W-1:0] prescale;
  logic [DUTY_W-1:0]     duty_shadow [NUM_CH];
  logic [DUTY_W-1:0]     duty_active [NUM_CH];
  logic [DUTY_W-1:0]     shadow_nxt  [NUM_CH];
  logic                  wr_ctrl;
  logic                  wr_duty;
  logic                  wr_prescale;
  logic                  tick;
  logic                  wrap;
  logic [DUTY_W-1:0]     pcnt;
  logic                  blink_mute;
  logic [31:0]           rd_mux;
  logic                  unused_bits;

  rgb_pwm_timebase #(.PRESCALE_W(PRESCALE_W)) u_timebase (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .prescale (prescale),
    .tick     (tick),
    .wrap     (wrap),
    .pcnt     (pcnt)
  );

  assign unused_bits = ^{bus.write_data, tick};

  always_comb begin
    wr_ctrl     = bus.cs && bus.we && (bus.address == ADDR_CTRL);
    wr_duty     = bus.cs && bus.we && (bus.address == ADDR_DUTY);
    wr_prescale = bus.cs && bus.we && (bus.address == ADDR_PRESCALE);
    enable_nxt  = wr_ctrl ? bus.write_data[0] : enable;
    for (int i = 0; i < NUM_CH; i++) begin
      shadow_nxt[i] = wr_duty ? bus.write_data[duty_lsb(i) +: DUTY_W] : duty_shadow[i];
    end
  end

  // Active duty follows the shadow while disabled and at each period wrap, so a
  // write landing on the wrap edge goes live immediately and leaves nothing pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable   <= 1'b0;
      prescale <= '0;
      pending  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_shadow[i] <= '0;
        duty_active[i] <= '0;
      end
    end else begin
      enable <= enable_nxt;
      if (wr_prescale) prescale <= bus.write_data[PRESCALE_W-1:0];
      for (int i = 0; i < NUM_CH; i++) duty_shadow[i] <= shadow_nxt[i];
      if (!enable || wrap) begin
        for (int i = 0; i < NUM_CH; i++) duty_active[i] <= shadow_nxt[i];
        pending <= 1'b0;
      end else if (wr_duty) begin
        pending <= 1'b1;
      end
    end
  end

`ifdef RGB_PWM_BLINK_EN
  logic               wr_blink;
  logic [BLINK_W-1:0] blink_on;
  logic [BLINK_W-1:0] blink_off;
  logic [BLINK_W-1:0] blink_cnt;
  logic [BLINK_W-1:0] blink_cnt_inc;
  logic [BLINK_W-1:0] blink_len;
  logic               blink_phase_off;
  logic               blink_active;

  assign wr_blink      = bus.cs && bus.we && (bus.address == ADDR_BLINK);
  assign blink_active  = (blink_on != '0) && (blink_off != '0);
  assign blink_mute    = blink_active && blink_phase_off;
  assign blink_cnt_inc = blink_cnt + 1'b1;
  assign blink_len     = blink_phase_off ? blink_off : blink_on;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_on        <= '0;
      blink_off       <= '0;
      blink_cnt       <= '0;
      blink_phase_off <= 1'b0;
    end else begin
      if (wr_blink) begin
        blink_on  <= bus.write_data[BLINK_ON_LSB  +: BLINK_W];
        blink_off <= bus.write_data[BLINK_OFF_LSB +: BLINK_W];
      end
      if (!enable || wr_blink || !blink_active) begin
        blink_cnt       <= '0;
        blink_phase_off <= 1'b0;
      end else if (wrap) begin
        if (blink_cnt_inc == blink_len) begin
          blink_cnt       <= '0;
          blink_phase_off <= !blink_phase_off;
        end else begin
          blink_cnt <= blink_cnt_inc;
        end
      end
    end
  end
`else
  assign blink_mute = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_CTRL:     rd_mux[0] = enable;
      ADDR_STATUS:   rd_mux[0] = pending;
      ADDR_DUTY:     rd_mux[NUM_CH*DUTY_W-1:0] = {duty_shadow[0], duty_shadow[1], duty_shadow[2]};
      ADDR_PRESCALE: rd_mux[PRESCALE_W-1:0] = prescale;
`ifdef RGB_PWM_BLINK_EN
      ADDR_BLINK:    rd_mux[2*BLINK_W-1:0] = {blink_on, blink_off};
`endif
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.ready     <= 1'b0;
      bus.read_data <= '0;
      pwm           <= '0;
      period_start  <= 1'b0;
    end else begin
      bus.ready     <= bus.cs;
      bus.read_data <= (bus.cs && !bus.we) ? rd_mux : '0;
      for (int i = 0; i < NUM_CH; i++) begin
        pwm[i] <= enable && !blink_mute && (pcnt < duty_active[i]);
      end
      // pcnt is zero after this edge either via wrap or because enable is rising.
      period_start <= enable_nxt && (wrap || !enable);
    end
  end

  assign led_en = enable;

endmodule

// File: doc/rgb_pwm_ctrl.md
# rgb_pwm_ctrl

- Memory-mapped PWM controller that drives the three PWM inputs and the enable of the iCE40 RGB LED hard driver.
- Produces per-channel 8-bit duty-cycle waveforms from a shared prescaled period counter.
- Duty updates are double-buffered so they change only at period boundaries.
- Sits on the core bus next to tk1. Its outputs wire directly to RGBLEDEN / RGB0PWM / RGB1PWM / RGB2PWM.

## Interface
Parameters:
- PRESCALE_W, 16, width of the prescaler reload value.

Ports:
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- cs  in  1  bus access strobe, one cycle.
- we  in  1  write qualifier for cs.
- address  in  8  register word address.
- write_data  in  32  write data.
- read_data  out  32  read data, valid while ready=1.
- ready  out  1  access acknowledge.
- led_en  out  1  to RGBLEDEN; equals CTRL.enable.
- pwm  out  3  pwm[0]/[1]/[2] to RGB0PWM/RGB1PWM/RGB2PWM (R/G/B).
- period_start  out  1  one-cycle pulse on the first cycle of each PWM period.

## Operation
Registers (word addresses):
- 0x08 CTRL, rw, bit0 enable.
- 0x09 STATUS, ro, bit0 update_pending.
- 0x10 DUTY, rw: [23:16] R, [15:8] G, [7:0] B. Writes go to the shadow register; reads return the shadow.
- 0x11 PRESCALE, rw, [PRESCALE_W-1:0].
- 0x12 BLINK, see Configuration.
- Other addresses: read 0, writes ignored.

Timebase:
- The prescaler counts 0..PRESCALE, then emits a tick and reloads 0. The compare is count >= PRESCALE, so lowering PRESCALE below the current count ticks on the next cycle.
- The 8-bit period counter increments on each tick and wraps 255→0.
- Period length is 256×(PRESCALE+1) clk cycles.

Duty:
- pwm[i] registered as enable && (pcnt < duty_active[i]).
- Duty 0 gives a constant 0. Duty 255 gives 255/256 high. Full-on is not possible.

Shadow update:
- A DUTY write sets update_pending.
- duty_active is loaded from the shadow on the tick that wraps pcnt 255→0, and pending clears.
- If a DUTY write coincides with that wrap tick, the written value loads directly into both shadow and active, and pending = 0.

Enable:
- While enable=0: prescaler and pcnt are held at 0, duty_active tracks the shadow every cycle, pwm = 0, and pending = 0.
- Clearing enable stops output on the next cycle.
- Setting enable starts a new period with pcnt = 0.

Reset values: all registers 0, pwm = 0, led_en = 0, period_start = 0, ready = 0, read_data = 0.

## Timing
- ready asserts the cycle after cs is sampled and lasts exactly one cycle. read_data is registered and valid in that same cycle.
- A write takes effect on the cs edge: after edge k the register holds the new value.
- pwm responds one cycle after its inputs change. Example: enable written at edge k with duty>0 gives pwm=1 after edge k+1.
- period_start is registered: high for one cycle after the edge on which pcnt becomes 0 (wrap, or enable rising).
- Asynchronous reset forces every output to its reset value immediately, including in the middle of a period.
- Back-to-back cs in consecutive cycles: each access is acknowledged one cycle later; no access is dropped.

## Configuration
Macro: RGB_PWM_BLINK_EN.

Defined:
- BLINK [15:8] = on_periods, [7:0] = off_periods.
- When both fields are nonzero, the output alternates on_periods active periods with off_periods periods of forced pwm=0.
- Blink phase counters advance on period wrap and reset when enable=0 or BLINK is written.
- When either field is 0, blink is inactive and the output runs continuously.

Undefined: no blink logic; address 0x12 reads 0 and writes are ignored.

## Structure
- Package rgb_pwm_pkg holds: the address constants (ADDR_CTRL, ADDR_STATUS, ADDR_DUTY, ADDR_PRESCALE, ADDR_BLINK), duty field offsets and widths, and DUTY_W = 8.
- Sub-module rgb_pwm_timebase contains the prescaler and period counter. It outputs tick, pcnt and wrap, and takes enable and prescale as inputs.

## Test plan
- Reset: reset_n low → pwm=0, led_en=0, ready=0; after release, reads of CTRL, DUTY and PRESCALE return 0.
- PRESCALE=0, DUTY=0x40_00_FF, enable=1 → per 256 cycles: pwm[0] high 64 cycles, pwm[1] high 0, pwm[2] high 255; period_start every 256 cycles.
- Mid-period DUTY write R=0x80 → current period still gives 64 high cycles and STATUS=1; next period gives 128 high cycles and STATUS=0.
- PRESCALE=3, R=0x40 → period 1024 cycles with pwm[0] high 256 cycles. Then write PRESCALE=0 while the prescaler count is 2 → tick on the next cycle.
- Drop reset_n while pwm[0]=1 mid-period → pwm=0 in the same cycle (asynchronous); all registers read 0 after release.
- With RGB_PWM_BLINK_EN defined, BLINK=0x0201 → repeating pattern of 2 active periods followed by 1 period with pwm=0. Without the macro, reading BLINK returns 0.
